// File: rtl/sram_cmd_parser.sv
// UART command front-end for the SRAM controller: parses 'W'/'R' commands, issues one request, returns read bytes.
// Optional inter-byte timeout for partial commands is built only when SRAM_CMD_TIMEOUT_EN is defined.
//
// state   | meaning
// IDLE    | waiting for an opcode byte
// ADDR2   | waiting for address bits [23:16]
// ADDR1   | waiting for address bits [15:8]
// ADDR0   | waiting for address bits [7:0]
// DATA    | waiting for the write data byte
// ISSUE   | one cycle, launches the SRAM request
// WAIT_WR | write outstanding, waiting for completion
// WAIT_RD | read outstanding, waiting for completion
// SEND    | read byte held until the transmitter is free
module sram_cmd_parser #(
    parameter int CLK_FREQ   = 60_000_000,
    parameter int TIMEOUT_MS = 10
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [7:0]  rx_data,
    input  logic        rx_received,
    output logic [23:0] sram_address,
    output logic [7:0]  sram_wdata,
    output logic        sram_wr_en,
    output logic        sram_rd_en,
    input  logic [7:0]  sram_rdata,
    input  logic        sram_completed,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_busy,
    output logic        busy,
    output logic        cmd_error,
    output logic        overrun
);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR2, S_ADDR1, S_ADDR0, S_DATA,
        S_ISSUE, S_WAIT_WR, S_WAIT_RD, S_SEND
    } state_t;

    state_t      r_state, w_next;
    logic        r_is_wr;
    logic [23:0] r_addr;
    logic [7:0]  r_wdata;
    logic [7:0]  r_tx_data;
    logic        r_wr_en, r_rd_en, r_cmd_error, r_overrun;
    logic        w_opcode_ok, w_in_cmd, w_accepting, w_timeout;

    assign w_opcode_ok = (rx_data == 8'h57) || (rx_data == 8'h52);
    assign w_in_cmd    = (r_state == S_ADDR2) || (r_state == S_ADDR1) ||
                         (r_state == S_ADDR0) || (r_state == S_DATA);
    assign w_accepting = (r_state == S_IDLE) || w_in_cmd;

`ifdef SRAM_CMD_TIMEOUT_EN
    localparam int TO_CYCLES = CLK_FREQ / 1000 * TIMEOUT_MS;
    logic [31:0] r_to_cnt;

    // Down-counter reloaded by every accepted command byte; terminal count aborts the command.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_to_cnt <= '0;
        end else if ((r_state == S_IDLE && w_next == S_ADDR2) || (w_in_cmd && rx_received)) begin
            r_to_cnt <= 32'(TO_CYCLES - 1);
        end else if (w_in_cmd && r_to_cnt != 32'd0) begin
            r_to_cnt <= r_to_cnt - 32'd1;
        end
    end

    assign w_timeout = w_in_cmd && !rx_received && (r_to_cnt == 32'd0);
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (rx_received && w_opcode_ok) w_next = S_ADDR2;
            S_ADDR2:   if (rx_received) w_next = S_ADDR1;
                       else if (w_timeout) w_next = S_IDLE;
            S_ADDR1:   if (rx_received) w_next = S_ADDR0;
                       else if (w_timeout) w_next = S_IDLE;
            S_ADDR0:   if (rx_received) w_next = r_is_wr ? S_DATA : S_ISSUE;
                       else if (w_timeout) w_next = S_IDLE;
            S_DATA:    if (rx_received) w_next = S_ISSUE;
                       else if (w_timeout) w_next = S_IDLE;
            S_ISSUE:   w_next = r_is_wr ? S_WAIT_WR : S_WAIT_RD;
            S_WAIT_WR: if (sram_completed) w_next = S_IDLE;
            S_WAIT_RD: if (sram_completed) w_next = S_SEND;
            S_SEND:    if (!tx_busy) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Request strobes are registered out of ISSUE, giving a fixed two-cycle latency from the last byte.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_is_wr     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_tx_data   <= '0;
            r_wr_en     <= 1'b0;
            r_rd_en     <= 1'b0;
            r_cmd_error <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_wr_en     <= (r_state == S_ISSUE) && r_is_wr;
            r_rd_en     <= (r_state == S_ISSUE) && !r_is_wr;
            r_cmd_error <= ((r_state == S_IDLE) && rx_received && !w_opcode_ok) || w_timeout;
            r_overrun   <= rx_received && !w_accepting;
            case (r_state)
                S_IDLE:    if (rx_received && w_opcode_ok) r_is_wr <= (rx_data == 8'h57);
                S_ADDR2:   if (rx_received) r_addr[23:16] <= rx_data;
                S_ADDR1:   if (rx_received) r_addr[15:8] <= rx_data;
                S_ADDR0:   if (rx_received) r_addr[7:0] <= rx_data;
                S_DATA:    if (rx_received) r_wdata <= rx_data;
                S_WAIT_RD: if (sram_completed) r_tx_data <= sram_rdata;
                default:   ;
            endcase
        end
    end

    assign sram_address = r_addr;
    assign sram_wdata   = r_wdata;
    assign sram_wr_en   = r_wr_en;
    assign sram_rd_en   = r_rd_en;
    assign tx_data      = r_tx_data;
    assign tx_start     = (r_state == S_SEND) && !tx_busy;
    assign busy         = (r_state != S_IDLE);
    assign cmd_error    = r_cmd_error;
    assign overrun      = r_overrun;

endmodule

// File: tb/tb_sram_cmd_parser.sv
// Directed bench for sram_cmd_parser with a behavioural SRAM model; define SRAM_CMD_TIMEOUT_EN to cover the timeout build.
module tb_sram_cmd_parser;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_received = 1'b0;
    logic [23:0] sram_address;
    logic [7:0]  sram_wdata;
    logic        sram_wr_en, sram_rd_en;
    logic [7:0]  sram_rdata = 8'h00;
    logic        sram_completed = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy = 1'b0;
    logic        busy, cmd_error, overrun;

    int n_cmp = 0;
    int n_mis = 0;
    int comp_delay = 3;
    int wr_cnt = 0, rd_cnt = 0, err_cnt = 0, ovr_cnt = 0, txs_cnt = 0, both_cnt = 0;
    int b_wr, b_rd, b_err, b_ovr, b_txs;
    logic [7:0] mem [logic [23:0]];
    logic [7:0] rd_val;

    sram_cmd_parser #(.CLK_FREQ(1_000_000), .TIMEOUT_MS(1)) dut (
        .clk(clk), .rstn(rstn), .rx_data(rx_data), .rx_received(rx_received),
        .sram_address(sram_address), .sram_wdata(sram_wdata),
        .sram_wr_en(sram_wr_en), .sram_rd_en(sram_rd_en),
        .sram_rdata(sram_rdata), .sram_completed(sram_completed),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
        .busy(busy), .cmd_error(cmd_error), .overrun(overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (sram_wr_en) wr_cnt++;
        if (sram_rd_en) rd_cnt++;
        if (sram_wr_en && sram_rd_en) both_cnt++;
        if (cmd_error) err_cnt++;
        if (overrun) ovr_cnt++;
        if (tx_start) txs_cnt++;
    end

    // SRAM model: unwritten locations read as addr[7:0]^0x5A.
    always begin
        @(posedge clk);
        if (rstn && (sram_wr_en || sram_rd_en)) begin
            if (sram_wr_en) mem[sram_address] = sram_wdata;
            else rd_val = mem.exists(sram_address) ? mem[sram_address] : (sram_address[7:0] ^ 8'h5A);
            repeat (comp_delay) @(posedge clk);
            #1;
            sram_rdata = rd_val;
            sram_completed = 1'b1;
            @(posedge clk);
            #1 sram_completed = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_received = 1'b1;
        @(negedge clk);
        rx_received = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int max_cyc);
        int k = 0;
        while (busy && k < max_cyc) begin
            @(negedge clk);
            k++;
        end
        chk(tag, {31'd0, busy}, 32'd0);
    endtask

    task automatic snap();
        b_wr = wr_cnt; b_rd = rd_cnt; b_err = err_cnt; b_ovr = ovr_cnt; b_txs = txs_cnt;
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_addr", {8'd0, sram_address}, 32'd0);
        chk("rst_outs", {24'd0, sram_wdata}, 32'd0);
        chk("rst_strobes", {26'd0, sram_wr_en, sram_rd_en, tx_start, busy, cmd_error, overrun}, 32'd0);
        rstn = 1'b1;

        // 1. Write then read with latency check
        snap();
        send(8'h57); send(8'h00); send(8'h12); send(8'h34); send(8'hA5);
        chk("wr_lat_early", {31'd0, sram_wr_en}, 32'd0);
        @(negedge clk);
        chk("wr_lat", {31'd0, sram_wr_en}, 32'd1);
        chk("wr_addr", {8'd0, sram_address}, 32'h001234);
        chk("wr_data", {24'd0, sram_wdata}, 32'hA5);
        wait_idle("wr_done", 50);
        send(8'h52); send(8'h00); send(8'h12); send(8'h34);
        chk("rd_lat_early", {31'd0, sram_rd_en}, 32'd0);
        @(negedge clk);
        chk("rd_lat", {31'd0, sram_rd_en}, 32'd1);
        chk("rd_addr", {8'd0, sram_address}, 32'h001234);
        wait_idle("rd_done", 50);
        chk("rd_txdata", {24'd0, tx_data}, 32'hA5);
        chk("t1_counts", {8'(wr_cnt - b_wr), 8'(rd_cnt - b_rd), 8'(txs_cnt - b_txs), 8'(err_cnt - b_err)}, 32'h01010100);

        // 2. Unknown opcode then a normal read
        snap();
        send(8'h41);
        repeat (3) @(negedge clk);
        chk("bad_op", {8'(err_cnt - b_err), 8'(wr_cnt - b_wr), 8'(rd_cnt - b_rd), 7'd0, busy}, 32'h01000000);
        send(8'h52); send(8'h00); send(8'h00); send(8'h01);
        wait_idle("t2_done", 50);
        chk("t2_txdata", {24'd0, tx_data}, 32'h5B);
        chk("t2_counts", {8'(rd_cnt - b_rd), 8'(txs_cnt - b_txs), 8'(err_cnt - b_err), 8'd0}, 32'h01010100);

        // 3. Overrun while a write is outstanding
        comp_delay = 200;
        snap();
        send(8'h57); send(8'h00); send(8'h00); send(8'h10); send(8'h3C);
        repeat (20) @(negedge clk);
        send(8'h52);
        repeat (3) @(negedge clk);
        chk("ovr_pulse", {8'(ovr_cnt - b_ovr), 23'd0, busy}, 32'h01000001);
        wait_idle("ovr_done", 400);
        repeat (8) @(negedge clk);
        chk("ovr_after", {8'(wr_cnt - b_wr), 8'(rd_cnt - b_rd), 15'd0, busy}, 32'h01000000);
        comp_delay = 3;

        // 4. Transmitter busy holds the result
        snap();
        tx_busy = 1'b1;
        send(8'h52); send(8'h00); send(8'h00); send(8'h10);
        repeat (50) @(negedge clk);
        chk("txb_hold", {8'(txs_cnt - b_txs), 8'(rd_cnt - b_rd), 15'd0, busy}, 32'h00010001);
        tx_busy = 1'b0;
        #1;
        chk("txb_start", {31'd0, tx_start}, 32'd1);
        @(negedge clk);
        chk("txb_after", {8'(txs_cnt - b_txs), 22'd0, tx_start, busy}, 32'h01000000);
        chk("txb_data", {24'd0, tx_data}, 32'h3C);

        // 5. Reset mid-command
        send(8'h57); send(8'h01); send(8'h02);
        chk("mid_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("mid_rst_data", {sram_wdata, tx_data, 16'd0}, 32'd0);
        chk("mid_rst_addr", {8'd0, sram_address}, 32'd0);
        chk("mid_rst_ctl", {26'd0, sram_wr_en, sram_rd_en, tx_start, busy, cmd_error, overrun}, 32'd0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        snap();
        send(8'h52); send(8'h00); send(8'h00); send(8'h00);
        @(negedge clk);
        chk("post_rst_rd", {7'd0, sram_rd_en, sram_address}, 32'h01000000);
        wait_idle("post_rst_done", 50);
        chk("post_rst_tx", {24'd0, tx_data}, 32'h5A);

        // 6. Partial command
        snap();
        send(8'h52); send(8'h00);
        repeat (1100) @(negedge clk);
`ifdef SRAM_CMD_TIMEOUT_EN
        chk("timeout", {8'(err_cnt - b_err), 8'(rd_cnt - b_rd), 15'd0, busy}, 32'h01000000);
`else
        chk("no_timeout", {8'(err_cnt - b_err), 8'(rd_cnt - b_rd), 15'd0, busy}, 32'h00000001);
`endif
        chk("never_both", both_cnt, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/sram_cmd_parser.md
Name: sram_cmd_parser

Overview:
Command front-end between uart_rx and sram_23lc1024.
- Consumes received UART bytes and assembles write/read commands (opcode, 24-bit address, optional data).
- Drives the SRAM controller's wr_en/rd_en/address_in/data_in and waits for completed.
- Returns each read byte to a UART transmitter through a start/busy handshake.

Parameters:
CLK_FREQ, 60_000_000, sysclk frequency in Hz (used only by the timeout feature).
TIMEOUT_MS, 10, inter-byte timeout in ms for a partial command (used only by the timeout feature).

Ports:
clk  in  1  system clock (sysclk)
rstn  in  1  asynchronous active-low reset
rx_data  in  8  byte from uart_rx
rx_received  in  1  one-cycle strobe, rx_data valid
sram_address  out  24  to sram address_in
sram_wdata  out  8  to sram data_in
sram_wr_en  out  1  one-cycle write request
sram_rd_en  out  1  one-cycle read request
sram_rdata  in  8  from sram data_out
sram_completed  in  1  one-cycle completion strobe from sram
tx_data  out  8  byte to UART transmitter
tx_start  out  1  one-cycle transmit request
tx_busy  in  1  transmitter busy
busy  out  1  high in any state except IDLE
cmd_error  out  1  one-cycle pulse: unknown opcode or timeout
overrun  out  1  one-cycle pulse: byte received while not accepting

Behaviour:
- Reset (rstn low, asynchronous): state IDLE; all outputs 0, including sram_address, sram_wdata and tx_data. The SRAM controller is not reset by this block.
- Commands, bytes in order:
  - 0x57 'W': A[23:16], A[15:8], A[7:0], D → write D at A.
  - 0x52 'R': A[23:16], A[15:8], A[7:0] → read A, send 1 byte back.
- All 24 address bits are stored and driven; the SRAM ignores bits above 16.
- States: IDLE, ADDR2, ADDR1, ADDR0, DATA, ISSUE, WAIT_WR, WAIT_RD, SEND.
- IDLE, on rx_received:
  - 0x57 or 0x52: latch opcode, go to ADDR2.
  - Any other value: pulse cmd_error on the next cycle, stay in IDLE.
- Address bytes:
  - ADDR2/ADDR1/ADDR0 each take one rx_received byte and load it into the matching sram_address byte.
  - After ADDR0: a write goes to DATA; a read goes to ISSUE.
- DATA: on rx_received, load sram_wdata, go to ISSUE.
- ISSUE, one cycle:
  - Write: sram_wr_en=1, go to WAIT_WR.
  - Read: sram_rd_en=1, go to WAIT_RD.
  - Latency: the request pulse is asserted exactly 2 clk after the rx_received of the last command byte.
- sram_address and sram_wdata stay stable from ISSUE until sram_completed.
- WAIT_WR: on sram_completed, go to IDLE.
- WAIT_RD: on sram_completed, tx_data<=sram_rdata, go to SEND.
- SEND:
  - While tx_busy=1, wait.
  - First cycle with tx_busy=0: tx_start=1 for one cycle, go to IDLE. tx_data holds until the next read.
- rx_received while in ISSUE, WAIT_WR, WAIT_RD or SEND: byte dropped, overrun pulses 1 cycle, state unchanged.
- sram_completed outside WAIT_WR/WAIT_RD: ignored.
- rx_received and sram_completed in the same cycle in WAIT_*: completion is taken and the byte is dropped with overrun.
- Never more than one outstanding SRAM request. wr_en and rd_en are never high together.

Optional Feature:
Macro: SRAM_CMD_TIMEOUT_EN
- Defined:
  - Counter of CLK_FREQ/1000*TIMEOUT_MS cycles, cleared on entry to ADDR2 and on every accepted byte in ADDR2/ADDR1/ADDR0/DATA.
  - On expiry in those states: return to IDLE, pulse cmd_error. No SRAM request is issued; sram_address keeps its partially loaded value.
  - The counter does not run in other states.
- Undefined: no counter is present; a partial command waits indefinitely for its remaining bytes.

Test Plan:
1. Write then read. Send 57 00 12 34 A5, then 52 00 12 34. Required:
   - sram_wr_en pulses once with sram_address=0x001234, sram_wdata=0xA5.
   - sram_rd_en pulses once with the same address.
   - Model returns 0xA5 → tx_data=0xA5 with one tx_start pulse.
2. Unknown opcode. Send 0x41, then 52 00 00 01. Required: cmd_error pulses once and no SRAM request for the 0x41. The read then completes normally.
3. Overrun. During WAIT_WR (model holds completed off for 200 cycles), send byte 0x52. Required:
   - overrun pulses once and state stays WAIT_WR.
   - After completed, state is IDLE and no read is issued.
4. Transmitter busy. Hold tx_busy=1 through a read completion, release after 50 cycles. Required: tx_start stays 0 while busy and pulses exactly once in the first cycle after release.
5. Reset mid-command. Send 57 01 02, then assert rstn low for 3 cycles and release. Required:
   - All outputs are 0 and busy=0.
   - A subsequent 52 00 00 00 issues rd_en with address 0x000000.
6. Timeout (SRAM_CMD_TIMEOUT_EN, CLK_FREQ=1_000_000, TIMEOUT_MS=1). Send 52 00, then idle for 1000+ cycles. Required:
   - cmd_error pulses once, state returns to IDLE, and no rd_en is issued.
   - Without the macro, busy stays 1.
